// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_arbiter
// Purpose  : Round-robin arbiter sharing one cacheline memory port between
//            the instruction cache (read-only) and the data cache (read/write).
// Revision : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SERVE_I = 2'd1;
    localparam logic [1:0] S_SERVE_D = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic w_i_req;
    logic w_d_req;
    logic w_pick_d;
    logic w_serving;

    assign w_i_req  = i_read;
    assign w_d_req  = d_read | d_write;
    // D wins alone, or on a tie when I held the previous grant.
    assign w_pick_d = w_d_req & (~w_i_req | ~last_d_q);

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (w_i_req | w_d_req) begin
                    state_d  = w_pick_d ? S_SERVE_D : S_SERVE_I;
                    last_d_d = w_pick_d;
                    addr_d   = w_pick_d ? d_address : i_address;
                    wr_d     = w_pick_d & d_write & ~d_read;
                    wdata_d  = d_wdata;
                end
            end
            S_SERVE_I, S_SERVE_D: begin
                if (mem_resp) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign w_serving   = (state_q == S_SERVE_I) | (state_q == S_SERVE_D);
    assign mem_read    = w_serving & ~wr_q;
    assign mem_write   = w_serving & wr_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;

    // Completion is forwarded in the same cycle, only to the owning cache.
    assign i_resp  = (state_q == S_SERVE_I) & mem_resp;
    assign d_resp  = (state_q == S_SERVE_D) & mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_arbiter
// Purpose  : Self-checking bench for cache_arbiter against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

    logic         clk;
    logic         rst;
    logic [31:0]  i_address;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_address;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    int total = 0;
    int bad   = 0;

    // Transaction-level model: who owns the port, what was latched, and how
    // many dead cycles remain before the next arbitration.
    int           m_owner;   // 0 none, 1 icache, 2 dcache
    int           m_last;    // 1 icache, 2 dcache
    int           m_gap;
    bit           m_wr;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;
    bit           i_done, d_done;

    cache_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_last = 1; m_gap = 0; m_wr = 0;
        m_addr = '0; m_wdata = '0; i_done = 0; d_done = 0;
    endtask

    task automatic check_outputs();
        bit srv;
        srv = (m_owner != 0) && !rst;
        chk("mem_read",  mem_read,  srv && !m_wr);
        chk("mem_write", mem_write, srv && m_wr);
        chk("i_resp",    i_resp,    srv && m_owner == 1 && mem_resp);
        chk("d_resp",    d_resp,    srv && m_owner == 2 && mem_resp);
        if (srv) chk("mem_address", mem_address, m_addr);
        if (srv && m_wr) chk("mem_wdata", mem_wdata, m_wdata);
        if (rst) begin
            chk("rst_address", mem_address, 256'h0);
            chk("rst_wdata",   mem_wdata,   256'h0);
        end
        if (i_resp) chk("i_rdata", i_rdata, mem_rdata);
        if (d_resp) chk("d_rdata", d_rdata, mem_rdata);
    endtask

    task automatic model_update();
        int win;
        if (rst) begin
            model_reset();
        end else if (m_owner != 0) begin
            if (mem_resp) begin
                if (m_owner == 1) i_done = 1; else d_done = 1;
                m_owner = 0;
                m_gap   = 1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            win = 0;
            if (i_read && (d_read || d_write)) win = (m_last == 1) ? 2 : 1;
            else if (d_read || d_write)        win = 2;
            else if (i_read)                   win = 1;
            if (win != 0) begin
                m_owner = win;
                m_last  = win;
                m_addr  = (win == 1) ? i_address : d_address;
                m_wr    = (win == 2) && d_write && !d_read;
                m_wdata = d_wdata;
            end
        end
    endtask

    // Inputs are set in the low phase; cyc() compares, adv() crosses the edge.
    task automatic cyc();
        #1;
        check_outputs();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        cyc();
        chk("reset_mem_read", mem_read, 1'b0);
        chk("reset_mem_write", mem_write, 1'b0);
        chk("reset_address", mem_address, 256'h0);
        adv();
        rst = 0;
    endtask

    logic [255:0] pat_a, pat_x;
    int w;

    initial begin
        rst = 1; i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // Lone dcache read.
        pat_a = {8{32'hA5A5_0001}};
        d_read = 1; d_address = 32'h0000_1000;
        cyc(); chk("t1_grant_cycle", mem_read, 1'b0);
        adv();
        cyc(); chk("t1_mem_read", mem_read, 1'b1); chk("t1_addr", mem_address, 32'h1000);
        adv();
        mem_resp = 1; mem_rdata = pat_a;
        cyc(); chk("t1_d_resp", d_resp, 1'b1); chk("t1_d_rdata", d_rdata, pat_a);
        chk("t1_i_resp", i_resp, 1'b0);
        adv();
        idle_inputs();
        cyc(); adv(); cyc(); adv();

        // Tie after reset: D first, then I three cycles after D's response.
        do_reset();
        pat_x = {8{32'h1234_5678}};
        i_read = 1; i_address = 32'h0000_2040;
        d_write = 1; d_address = 32'h0000_3000; d_wdata = pat_x;
        cyc(); adv();
        d_address = 32'hDEAD_0000; d_wdata = ~pat_x;
        cyc(); chk("t2_mem_write", mem_write, 1'b1); chk("t2_mem_read", mem_read, 1'b0);
        chk("t2_wdata_held", mem_wdata, pat_x); chk("t2_addr_held", mem_address, 32'h3000);
        adv();
        mem_resp = 1;
        cyc(); chk("t2_d_resp", d_resp, 1'b1);
        adv();
        mem_resp = 0; d_write = 0;
        cyc(); chk("t2_gap1", mem_read, 1'b0); adv();
        cyc(); chk("t2_gap2", mem_read, 1'b0); adv();
        cyc(); chk("t2_i_grant", mem_read, 1'b1); chk("t2_i_addr", mem_address, 32'h2040);
        adv();
        mem_resp = 1;
        cyc(); chk("t2_i_resp", i_resp, 1'b1);
        adv();
        mem_resp = 0;

        // Continuous contention alternates D,I,D,I,D,I with two dead cycles.
        i_read = 1; i_address = 32'h0000_A000;
        d_read = 1; d_address = 32'h0000_B000;
        for (int k = 0; k < 6; k++) begin
            w = 0;
            cyc();
            while (!mem_read && w < 10) begin
                adv(); w++; cyc();
            end
            chk("alt_owner", mem_address, (k % 2 == 0) ? 32'hB000 : 32'hA000);
            chk("alt_gap", w, 2);
            adv();
            mem_resp = 1;
            cyc();
            chk("alt_resp", (k % 2 == 0) ? d_resp : i_resp, 1'b1);
            adv();
            mem_resp = 0;
        end
        idle_inputs();
        cyc(); adv(); cyc(); adv();

        // Stray mem_resp while idle is ignored.
        mem_resp = 1;
        cyc(); chk("idle_i_resp", i_resp, 1'b0); chk("idle_d_resp", d_resp, 1'b0);
        adv();
        mem_resp = 0;
        cyc(); chk("idle_stays", mem_read | mem_write, 1'b0); adv();

        // Simultaneous d_read and d_write resolves to a read.
        d_read = 1; d_write = 1; d_address = 32'h0000_4400;
        cyc(); adv();
        cyc(); chk("rw_read", mem_read, 1'b1); chk("rw_write", mem_write, 1'b0);
        adv();
        mem_resp = 1;
        cyc(); chk("rw_resp", d_resp, 1'b1); adv();
        idle_inputs();
        cyc(); adv(); cyc(); adv();

        // Asynchronous reset in the middle of an icache transaction.
        i_read = 1; i_address = 32'h0000_5500;
        cyc(); adv();
        cyc(); chk("ar_pre", mem_read, 1'b1);
        rst = 1;
        #1;
        chk("ar_read", mem_read, 1'b0); chk("ar_write", mem_write, 1'b0);
        chk("ar_addr", mem_address, 256'h0); chk("ar_wdata", mem_wdata, 256'h0);
        chk("ar_iresp", i_resp, 1'b0); chk("ar_dresp", d_resp, 1'b0);
        adv();
        rst = 0;
        cyc(); adv();
        cyc(); chk("ar_regrant", mem_read, 1'b1); chk("ar_readdr", mem_address, 32'h5500);
        adv();
        mem_resp = 1;
        cyc(); chk("ar_resp", i_resp, 1'b1); adv();
        idle_inputs();
        cyc(); adv();

        // Randomised traffic with caches that hold requests until their resp.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (i_done) begin
                i_read = 0; i_done = 0;
            end else if (!i_read && ($urandom % 3 == 0)) begin
                i_read = 1;
            end
            if (d_done) begin
                d_read = 0; d_write = 0; d_done = 0;
            end else if (!d_read && !d_write && ($urandom % 3 == 0)) begin
                w = $urandom % 10;
                d_read  = (w < 5) || (w == 9);
                d_write = (w >= 5);
            end
            i_address = $urandom;
            d_address = $urandom;
            d_wdata   = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
            mem_rdata = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
            mem_resp  = (m_owner != 0) ? ($urandom % 3 == 0) : ($urandom % 6 == 0);
            cyc();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
